// File: rtl/search_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : search_scheduler
//  Description : Round-robin block scheduler for the password-search cores;
//                latches the first hit and streams its index MSB byte first.
//  Revision    : 1.0
// ============================================================================
module search_scheduler #(
    parameter int NCORES   = 4,
    parameter int IDX_W    = 40,
    parameter int BLK_LOG2 = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic [NCORES-1:0]       CORE_REQ,
    output logic [NCORES-1:0]       CORE_GNT,
    output logic [IDX_W-1:0]        CORE_BASE,
    input  logic [NCORES-1:0]       CORE_HIT,
    input  logic [NCORES*IDX_W-1:0] CORE_HIT_IDX,
    output logic                    CORE_ABORT,
    output logic [7:0]              TX_DATA,
    output logic                    TX_VALID,
    input  logic                    TX_READY,
    output logic                    FLAG,
    output logic                    FOUND,
    output logic                    DONE
);

    localparam int RR_W   = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int NBYTES = IDX_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [RR_W-1:0]   LAST_CORE = RR_W'(NCORES - 1);
    localparam logic [IDX_W:0]    BLK_INC   = {{IDX_W{1'b0}}, 1'b1} << BLK_LOG2;
    localparam logic [NCORES-1:0] GNT_ONE   = {{(NCORES-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_REPORT = 3'd2,
        S_END_F  = 3'd3,
        S_END_NF = 3'd4
    } state_t;

    state_t             state_q;
    logic [NCORES-1:0]  gnt_q;
    logic [IDX_W-1:0]   base_q;
    logic [IDX_W-1:0]   next_base_q;
    logic [IDX_W-1:0]   idx_q;
    logic [RR_W-1:0]    rr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               exhausted_q;
    logic               abort_q;
    logic               tx_valid_q;
    logic               flag_q;
    logic               found_q;
    logic               done_q;

    logic               win_found_d;
    logic [RR_W-1:0]    win_d;
    logic [RR_W-1:0]    rr_d;
    logic               hit_any_d;
    logic [IDX_W-1:0]   hit_idx_d;
    logic [IDX_W-1:0]   next_base_d;
    logic               carry_d;

    // Two passes: requesters at/after the pointer first, then the wrapped ones.
    always_comb begin
        win_found_d = 1'b0;
        win_d       = '0;
        for (int c = 0; c < NCORES; c++) begin
            if (!win_found_d && CORE_REQ[c] && (c >= int'(rr_q))) begin
                win_found_d = 1'b1;
                win_d       = RR_W'(c);
            end
        end
        for (int c = 0; c < NCORES; c++) begin
            if (!win_found_d && CORE_REQ[c]) begin
                win_found_d = 1'b1;
                win_d       = RR_W'(c);
            end
        end
    end

    always_comb begin
        rr_d = (win_d == LAST_CORE) ? '0 : win_d + RR_W'(1);
    end

    // Scanning downward leaves the lowest-numbered hitter's index in place.
    always_comb begin
        hit_any_d = |CORE_HIT;
        hit_idx_d = '0;
        for (int c = NCORES - 1; c >= 0; c--) begin
            if (CORE_HIT[c]) begin
                hit_idx_d = CORE_HIT_IDX[c*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        {carry_d, next_base_d} = {1'b0, next_base_q} + BLK_INC;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            base_q      <= '0;
            next_base_q <= '0;
            idx_q       <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            exhausted_q <= 1'b0;
            abort_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            flag_q      <= 1'b0;
            found_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            gnt_q <= '0;
            case (state_q)
                S_IDLE, S_END_F, S_END_NF: begin
                    if (START) begin
                        state_q     <= S_RUN;
                        flag_q      <= 1'b1;
                        found_q     <= 1'b0;
                        done_q      <= 1'b0;
                        abort_q     <= 1'b0;
                        tx_valid_q  <= 1'b0;
                        next_base_q <= '0;
                        exhausted_q <= 1'b0;
                        rr_q        <= '0;
                        cnt_q       <= '0;
                        idx_q       <= '0;
                    end
                end
                S_RUN: begin
                    if (hit_any_d) begin
                        state_q    <= S_REPORT;
                        idx_q      <= hit_idx_d;
                        found_q    <= 1'b1;
                        abort_q    <= 1'b1;
                        tx_valid_q <= 1'b1;
                        cnt_q      <= '0;
                    end else if (exhausted_q) begin
                        if (&CORE_REQ) begin
                            state_q <= S_END_NF;
                            flag_q  <= 1'b0;
                            done_q  <= 1'b1;
                            abort_q <= 1'b1;
                        end
                    end else if (win_found_d) begin
                        gnt_q       <= GNT_ONE << win_d;
                        base_q      <= next_base_q;
                        next_base_q <= next_base_d;
                        exhausted_q <= carry_d;
                        rr_q        <= rr_d;
                    end
                end
                S_REPORT: begin
                    if (TX_READY) begin
                        if (cnt_q == LAST_BYTE) begin
                            state_q    <= S_END_F;
                            tx_valid_q <= 1'b0;
                            flag_q     <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            idx_q <= idx_q << 8;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign CORE_GNT   = gnt_q;
    assign CORE_BASE  = base_q;
    assign CORE_ABORT = abort_q;
    assign TX_DATA    = idx_q[IDX_W-1 -: 8];
    assign TX_VALID   = tx_valid_q;
    assign FLAG       = flag_q;
    assign FOUND      = found_q;
    assign DONE       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_search_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_search_scheduler
//  Description : Directed self-checking bench for search_scheduler.
//  Revision    : 1.0
// ============================================================================
module tb_search_scheduler;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic [39:0]  base;
    logic [3:0]   hit;
    logic [159:0] hit_idx;
    logic         abort;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         flag;
    logic         found;
    logic         done;

    // Narrow instance used for the exhaustion scenario
    logic         s_start;
    logic [3:0]   s_req;
    logic [3:0]   s_gnt;
    logic [11:0]  s_base;
    logic [3:0]   s_hit;
    logic [47:0]  s_hit_idx;
    logic         s_abort;
    logic [7:0]   s_tx_data;
    logic         s_tx_valid;
    logic         s_tx_ready;
    logic         s_flag;
    logic         s_found;
    logic         s_done;

    int checks;
    int failures;

    search_scheduler #(.NCORES(4), .IDX_W(40), .BLK_LOG2(8)) u_dut (
        .CLK          (clk),
        .RESET        (rst),
        .START        (start),
        .CORE_REQ     (req),
        .CORE_GNT     (gnt),
        .CORE_BASE    (base),
        .CORE_HIT     (hit),
        .CORE_HIT_IDX (hit_idx),
        .CORE_ABORT   (abort),
        .TX_DATA      (tx_data),
        .TX_VALID     (tx_valid),
        .TX_READY     (tx_ready),
        .FLAG         (flag),
        .FOUND        (found),
        .DONE         (done)
    );

    search_scheduler #(.NCORES(4), .IDX_W(12), .BLK_LOG2(8)) u_small (
        .CLK          (clk),
        .RESET        (rst),
        .START        (s_start),
        .CORE_REQ     (s_req),
        .CORE_GNT     (s_gnt),
        .CORE_BASE    (s_base),
        .CORE_HIT     (s_hit),
        .CORE_HIT_IDX (s_hit_idx),
        .CORE_ABORT   (s_abort),
        .TX_DATA      (s_tx_data),
        .TX_VALID     (s_tx_valid),
        .TX_READY     (s_tx_ready),
        .FLAG         (s_flag),
        .FOUND        (s_found),
        .DONE         (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] bytes_a [5];
    logic [7:0] bytes_b [5];

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        req        = '0;
        hit        = '0;
        hit_idx    = '0;
        tx_ready   = 1'b0;
        s_start    = 1'b0;
        s_req      = '0;
        s_hit      = '0;
        s_hit_idx  = '0;
        s_tx_ready = 1'b0;
        bytes_a    = '{8'hAB, 8'h12, 8'h34, 8'h56, 8'h78};
        bytes_b    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

        tick();
        tick();
        chk("rst_gnt",   64'(gnt), 64'h0);
        chk("rst_base",  64'(base), 64'h0);
        chk("rst_abort", 64'(abort), 64'h0);
        chk("rst_valid", 64'(tx_valid), 64'h0);
        chk("rst_flags", 64'({flag, found, done}), 64'h0);
        rst = 1'b0;
        tick();
        chk("idle_flag", 64'(flag), 64'h0);

        // Four simultaneous requesters, each drops its request once granted
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_flag", 64'(flag), 64'h1);
        chk("run_gnt0", 64'(gnt), 64'h0);
        req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("t1_gnt",  64'(gnt), 64'(4'b0001 << g));
            chk("t1_base", 64'(base), 64'(g * 256));
            req[g] = 1'b0;
        end
        tick();
        chk("t1_idle_gnt", 64'(gnt), 64'h0);

        // Core 2 held, core 0 re-requests after each grant
        req = 4'b0101;
        tick();
        chk("t2_gnt_a", 64'(gnt), 64'h1);
        chk("t2_base_a", 64'(base), 64'h400);
        req = 4'b0100;
        tick();
        chk("t2_gnt_b", 64'(gnt), 64'h4);
        chk("t2_base_b", 64'(base), 64'h500);
        req = 4'b0101;
        tick();
        chk("t2_gnt_c", 64'(gnt), 64'h1);
        chk("t2_base_c", 64'(base), 64'h600);
        req = 4'b0100;
        tick();
        chk("t2_gnt_d", 64'(gnt), 64'h4);
        chk("t2_base_d", 64'(base), 64'h700);
        req = 4'b0000;
        tick();
        chk("t2_idle_gnt", 64'(gnt), 64'h0);

        // Hits on cores 3 and 1 with a pending request: core 1 wins, no grant
        req                 = 4'b0001;
        hit                 = 4'b1010;
        hit_idx[40 +: 40]   = 40'hAB12345678;
        hit_idx[120 +: 40]  = 40'h1122334455;
        tx_ready            = 1'b1;
        tick();
        hit = '0;
        req = '0;
        chk("t3_gnt",   64'(gnt), 64'h0);
        chk("t3_found", 64'(found), 64'h1);
        chk("t3_abort", 64'(abort), 64'h1);
        chk("t3_flag",  64'(flag), 64'h1);
        for (int k = 0; k < 5; k++) begin
            chk("t3_valid", 64'(tx_valid), 64'h1);
            chk("t3_byte",  64'(tx_data), 64'(bytes_a[k]));
            tick();
        end
        chk("t3_valid_end", 64'(tx_valid), 64'h0);
        chk("t3_end_flags", 64'({flag, found, done, abort}), 64'b0101);

        // Hit outside RUN is ignored
        hit             = 4'b0001;
        hit_idx[0 +: 40] = 40'hFFFFFFFFFF;
        tick();
        hit = '0;
        tick();
        chk("t3_ignore_valid", 64'(tx_valid), 64'h0);
        chk("t3_ignore_flag",  64'(flag), 64'h0);

        // Back-pressure: READY low for five cycles on byte 2
        tx_ready = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart", 64'({flag, found, done, abort}), 64'b1000);
        hit              = 4'b0100;
        hit_idx[80 +: 40] = 40'h0102030405;
        tick();
        hit = '0;
        chk("t4_b0", 64'(tx_data), 64'h01);
        tx_ready = 1'b1;
        tick();
        chk("t4_b1", 64'(tx_data), 64'h02);
        tick();
        chk("t4_b2", 64'(tx_data), 64'h03);
        tx_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("t4_hold_data",  64'(tx_data), 64'h03);
            chk("t4_hold_valid", 64'(tx_valid), 64'h1);
        end
        tx_ready = 1'b1;
        for (int k = 2; k < 5; k++) begin
            chk("t4_byte",  64'(tx_data), 64'(bytes_b[k]));
            chk("t4_valid", 64'(tx_valid), 64'h1);
            tick();
        end
        chk("t4_valid_end", 64'(tx_valid), 64'h0);

        // Narrow search space runs to exhaustion
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_req   = 4'b1111;
        chk("t5_flag", 64'(s_flag), 64'h1);
        for (int g = 0; g < 16; g++) begin
            tick();
            chk("t5_gnt",  64'(s_gnt), 64'(4'b0001 << (g % 4)));
            chk("t5_base", 64'(s_base), 64'(g * 256));
        end
        tick();
        chk("t5_no_gnt17", 64'(s_gnt), 64'h0);
        chk("t5_done",     64'(s_done), 64'h1);
        chk("t5_flag_end", 64'(s_flag), 64'h0);
        chk("t5_abort",    64'(s_abort), 64'h1);
        tick();
        chk("t5_no_gnt18", 64'(s_gnt), 64'h0);
        s_req = '0;

        // Reset in the middle of the report
        start = 1'b1;
        tick();
        start           = 1'b0;
        hit             = 4'b0001;
        hit_idx[0 +: 40] = 40'hAB12345678;
        tx_ready        = 1'b1;
        tick();
        hit = '0;
        tick();
        tick();
        chk("t6_byte2", 64'(tx_data), 64'h34);
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt",   64'(gnt), 64'h0);
        chk("t6_rst_base",  64'(base), 64'h0);
        chk("t6_rst_tx",    64'({tx_valid, tx_data}), 64'h0);
        chk("t6_rst_flags", 64'({flag, found, done, abort}), 64'h0);
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        req   = 4'b0100;
        tick();
        req = '0;
        chk("t6_gnt",   64'(gnt), 64'h4);
        chk("t6_base",  64'(base), 64'h0);
        chk("t6_found", 64'(found), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
